// File: rtl/sc_mmio_pkg.sv
// Shared constants and helpers for the data-memory / memory-mapped I/O block.
package sc_mmio_pkg;

    localparam int OFF_OUT0   = 0;
    localparam int OFF_IN0    = 8;
    localparam int OFF_STATUS = 16;
    localparam int OFF_MASK   = 17;

    // Widest bus the byte-lane helper handles; callers zero-extend and truncate.
    localparam int MAX_W  = 256;
    localparam int MAX_BE = MAX_W / 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] apply_be(input logic [MAX_W-1:0]  old_w,
                                                  input logic [MAX_W-1:0]  new_w,
                                                  input logic [MAX_BE-1:0] lanes);
        logic [MAX_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_BE; i++) begin
            if (lanes[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_in_sync.sv
// One input channel: two-flop synchroniser, previous-value register and change pulse.
module mmio_in_sync #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync_q,
    output logic         change
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign sync_q = sync2;
    assign change = (sync2 != prev);

endmodule

// File: rtl/sc_datamem_mmio.sv
// CPU data RAM plus memory-mapped output registers, synchronised inputs,
// sticky change flags and a maskable interrupt. Reads are registered.
module sc_datamem_mmio
    import sc_mmio_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 32,
    parameter int N_OUT      = 3,
    parameter int N_IN       = 2,
    parameter int IO_SEL_BIT = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   we,
    input  logic                   re,
    input  logic [DATA_W/8-1:0]    be,
    input  logic [31:0]            addr,
    input  logic [DATA_W-1:0]      datain,
    input  logic [N_IN*DATA_W-1:0] in_port,
    output logic [DATA_W-1:0]      dataout,
    output logic                   rvalid,
    output logic [N_OUT*DATA_W-1:0] out_port,
    output logic                   irq
);

    localparam int AW = (clog2(MEM_WORDS) < 1) ? 1 : clog2(MEM_WORDS);

    logic [DATA_W-1:0] ram     [MEM_WORDS];
    logic [DATA_W-1:0] out_reg [N_OUT];
    logic [DATA_W-1:0] in_val  [N_IN];
    logic [N_IN-1:0]   chg;
    logic [N_IN-1:0]   flags;
    logic [N_IN-1:0]   mask;
    logic [N_IN-1:0]   clr;
    logic [DATA_W-1:0] rd_word;
    logic              io_sel;
    logic [4:0]        off;
    logic [AW-1:0]     ram_idx;
    logic              unused_addr;

    assign io_sel      = addr[IO_SEL_BIT];
    assign off         = addr[6:2];
    assign ram_idx     = addr[AW+1:2];
    assign unused_addr = ^addr;

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        mmio_in_sync #(.W(DATA_W)) u_sync (
            .clock  (clock),
            .reset  (reset),
            .din    (in_port[k*DATA_W +: DATA_W]),
            .sync_q (in_val[k]),
            .change (chg[k])
        );
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign out_port[k*DATA_W +: DATA_W] = out_reg[k];
    end

    always_comb begin
        rd_word = '0;
        if (!io_sel) begin
            rd_word = ram[ram_idx];
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (off == 5'(OFF_OUT0 + k)) rd_word = out_reg[k];
            end
            for (int k = 0; k < N_IN; k++) begin
                if (off == 5'(OFF_IN0 + k)) rd_word = in_val[k];
            end
            if (off == 5'(OFF_STATUS)) rd_word = DATA_W'(flags);
            if (off == 5'(OFF_MASK))   rd_word = DATA_W'(mask);
        end
    end

    // Flags and mask fit in byte lane 0 since there are at most 8 inputs.
    always_comb begin
        clr = '0;
        if (we && io_sel && off == 5'(OFF_STATUS) && be[0]) clr = datain[N_IN-1:0];
    end

    // RAM is left unreset so it can map onto memory macros.
    always_ff @(posedge clock) begin
        if (!reset && we && !io_sel) begin
            ram[ram_idx] <= DATA_W'(apply_be(MAX_W'(ram[ram_idx]), MAX_W'(datain), MAX_BE'(be)));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N_OUT; k++) out_reg[k] <= '0;
            flags   <= '0;
            mask    <= '0;
            dataout <= '0;
            rvalid  <= 1'b0;
        end else begin
            if (we && io_sel) begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (off == 5'(OFF_OUT0 + k)) begin
                        out_reg[k] <= DATA_W'(apply_be(MAX_W'(out_reg[k]), MAX_W'(datain), MAX_BE'(be)));
                    end
                end
                if (off == 5'(OFF_MASK) && be[0]) mask <= datain[N_IN-1:0];
            end
            // A new change detected in the same cycle as a clear keeps the flag set.
            flags <= (flags & ~clr) | chg;
            if (re && !we) begin
                dataout <= rd_word;
                rvalid  <= 1'b1;
            end else begin
                rvalid  <= 1'b0;
            end
        end
    end

    assign irq = |(flags & mask);

endmodule
